// File: rtl/example_stream_fifo.sv
// rtl/example_stream_fifo.sv - synchronous valid/ready stream FIFO with first-word-fall-through output
//
// Purpose: buffers up to DEPTH words between a stream source and a stream sink,
// presenting the head word combinationally from storage (no same-cycle bypass)
// and applying back-pressure when full.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     upstream word valid
//   in_ready     FIFO can accept a word (registered state and rst only)
//   in_data      upstream word
//   out_valid    head word available
//   out_ready    downstream accepts the head word
//   out_data     head word (don't-care while out_valid=0)
//   level        current fill count         (only with EXAMPLE_STREAM_FIFO_LEVEL_EN)
//   almost_full  level >= ALMOST_FULL_LEVEL (only with EXAMPLE_STREAM_FIFO_LEVEL_EN)
//
// Optional feature macro: EXAMPLE_STREAM_FIFO_LEVEL_EN

module example_stream_fifo #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data
`ifdef EXAMPLE_STREAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        almost_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity check.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_params
    $error("example_stream_fifo: illegal DEPTH or ALMOST_FULL_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_fire, rd_fire;

  // in_ready looks only at registered count (plus rst), so a read in the same
  // cycle never opens a slot for a write: no out_ready -> in_ready path.
  assign in_ready  = !rst && (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_fire  = in_valid && in_ready;
    rd_fire  = out_valid && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; wr_fire is already gated off during rst.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef EXAMPLE_STREAM_FIFO_LEVEL_EN
  logic almost_full_q, almost_full_d;

  // Compare against the next count so the flag lands on the same edge as level.
  always_comb begin
    almost_full_d = (count_d >= CNT_W'(ALMOST_FULL_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= almost_full_d;
  end

  assign level       = count_q;
  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_example_stream_fifo.sv
// tb/tb_example_stream_fifo.sv - randomized self-checking bench for example_stream_fifo

module tb_example_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef EXAMPLE_STREAM_FIFO_LEVEL_EN
  logic [4:0]    level;
  logic          almost_full;
`endif

  example_stream_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef EXAMPLE_STREAM_FIFO_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO content as a plain queue, head at index 0.
  logic [DW-1:0] model[$];
  logic          last_wr, last_rd;
  logic [DW-1:0] last_rd_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the handshake rules at the rising edge.
  task automatic step(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic exp_ready, exp_valid;
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ready = !r && (model.size() != DEPTH);
    exp_valid = (model.size() != 0);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("out_data", out_data, model[0]);
`ifdef EXAMPLE_STREAM_FIFO_LEVEL_EN
    check("level", level, model.size());
    check("almost_full", almost_full, model.size() >= AFL);
`endif
    last_wr      = iv && exp_ready;
    last_rd      = exp_valid && ordy;
    last_rd_data = out_data;
    @(posedge clk);
    if (r) model.delete();
    else begin
      if (last_rd) void'(model.pop_front());
      if (last_wr) model.push_back(d);
    end
    #1;
  endtask

  initial begin
    int rx, tx, cyc;
    // Bring the DUT into a known state before any comparison.
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset then idle.
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Single word held under back-pressure, then one read.
    step(0, 1, 8'hA5, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    check("single_read_fired", last_rd, 1'b1);
    step(0, 0, 8'h00, 1);

    // Fill to full, refuse a 17th word, drain in order.
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(i), 0);
    step(0, 1, 8'hFF, 0);
    check("full_refuse", last_wr, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'hFF, 1);
      check("drain_order", last_rd_data, i);
    end
    step(0, 0, 8'h00, 0);

    // Full with simultaneous read and write: read only, write next cycle.
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(8'h40 + i), 0);
    step(0, 1, 8'h77, 1);
    check("full_rw_write", last_wr, 1'b0);
    check("full_rw_read", last_rd, 1'b1);
    check("full_rw_count", model.size(), DEPTH - 1);
    step(0, 1, 8'h77, 0);
    check("full_rw_retry", last_wr, 1'b1);
    check("full_rw_count2", model.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Randomized streaming of 0..39 with pointer wrap.
    rx = 0; tx = 0; cyc = 0;
    while (rx < 40 && cyc < 2000) begin
      step(0, (tx < 40) && ($urandom_range(0, 3) != 0), DW'(tx), $urandom_range(0, 2) != 0);
      if (last_wr) tx++;
      if (last_rd) begin
        check("stream_order", last_rd_data, rx);
        rx++;
      end
      cyc++;
    end
    check("stream_received", rx, 40);
    step(0, 0, 8'h00, 0);

    // Reset mid-operation discards buffered words.
    for (int i = 0; i < AFL; i++) step(0, 1, DW'(8'h80 + i), 0);
    check("mid_fill", model.size(), AFL);
    step(1, 1, 8'h99, 1);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h3C, 0);
    step(0, 0, 8'h00, 1);
    check("post_reset_first", last_rd_data, 8'h3C);
    step(0, 0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/example_stream_fifo.md
Name: example_stream_fifo

Overview:
- Synchronous valid/ready stream FIFO; the example DUT instantiated by the user-guide VUnit SystemVerilog testbenches.
- Sits between a stream source (upstream producer or bench driver) and a stream sink (downstream consumer or bench monitor).
- Buffers up to DEPTH words with first-word-fall-through output and full back-pressure.

Parameters:
- DATA_WIDTH, 8, width of the data path in bits (>=1).
- DEPTH, 16, number of storage words; power of two, >=2.
- ALMOST_FULL_LEVEL, 12, fill level at which almost_full asserts (1..DEPTH); used only with the optional feature.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  DATA_WIDTH  upstream word.
- out_valid  output  1  head word available.
- out_ready  input  1  downstream accepts the head word.
- out_data  output  DATA_WIDTH  head word.
- level  output  $clog2(DEPTH)+1  current fill count (optional feature only).
- almost_full  output  1  level >= ALMOST_FULL_LEVEL (optional feature only).

Behaviour:
- Reset is synchronous and active-high: on a clk edge with rst=1, wr_ptr=0, rd_ptr=0, count=0, so out_valid=0. in_ready=0 while rst=1 and 1 in the first cycle after rst falls. The storage array is not cleared and out_data is don't-care while out_valid=0.
- Write fires when in_valid && in_ready. The word is stored at mem[wr_ptr], and wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Read fires when out_valid && out_ready, and rd_ptr increments modulo DEPTH.
- count tracks fill level and ranges 0..DEPTH:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on a simultaneous write and read.
- in_ready = !rst && (count != DEPTH), derived from registered state only. There is no combinational path from out_ready to in_ready.
- When full, a write is refused even if a read fires in the same cycle. in_ready returns to 1 the cycle after that read.
- out_valid = (count != 0). out_data = mem[rd_ptr] (first-word-fall-through).
- Latency: a word written into an empty FIFO at edge N is presented with out_valid=1 from edge N onward (visible in cycle N+1). There is no bypass in the same cycle.
- Empty with a simultaneous write: no read can fire because out_valid=0. After the edge, count=1.
- Stream rule: while out_valid && !out_ready, out_data and out_valid are held stable. New writes never disturb the head word.
- Order is strictly preserved, with no duplication or loss.
- in_valid with in_ready=0 has no effect. Upstream must hold in_data until accepted.
- Reset mid-operation: all buffered words are discarded on the reset edge. out_valid=0 on the following cycle regardless of out_ready.
- Pointer width is $clog2(DEPTH). count width is $clog2(DEPTH)+1 so that the full value DEPTH is representable.

Optional Feature:
- Macro: EXAMPLE_STREAM_FIFO_LEVEL_EN.
- Defined: ports level and almost_full exist.
  - level = count, updated on the same edge as count.
  - almost_full = (count >= ALMOST_FULL_LEVEL), registered, with the same timing as level.
  - Both are 0 after reset.
- Undefined: neither port exists and no comparator logic is generated. Core behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> out_valid=0 throughout, in_ready=0 during reset and 1 on the first cycle after.
- Single word: write 0xA5 into empty FIFO, out_ready=0 -> out_valid=1 and out_data=0xA5 on the next cycle, held 5 cycles. Then out_ready=1 -> read fires once and out_valid=0 after.
- Fill to full (DEPTH=16): write 0x00..0x0F with out_ready=0 -> in_ready=0 after 16th write, 17th word 0xFF refused. Read all 16 -> 0x00..0x0F in order, 0xFF never appears.
- Full with simultaneous read and write: full FIFO, in_valid=1 and out_ready=1 in the same cycle -> only the read fires, count=15. In the next cycle the write fires and count=16.
- Wrap and streaming: 40 words 0..39 with in_valid and out_ready both randomly toggled -> output sequence exactly 0..39, pointers wrap at least twice, with no stall while count is strictly between 0 and DEPTH.
- Reset mid-operation (feature on, ALMOST_FULL_LEVEL=12): write 12 words -> level=12, almost_full=1. Assert rst for 1 cycle -> level=0, almost_full=0, out_valid=0. A new word 0x3C then comes out first.
